// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one req/ack memory between a read-only fetch port and a priority data port
// with a starvation guard that forces a fetch grant after STARVE_LIMIT back-to-back data grants.
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack,
    output logic          gnt_d
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
    localparam logic [CW-1:0] ONE = CW'(1);
    typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D} state_t;
    state_t state, state_nx;
    logic [CW-1:0] starve_cnt, starve_nx;
    logic grant_d, start;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            starve_cnt <= '0;
        end else begin
            state <= state_nx;
            starve_cnt <= starve_nx;
        end
    // Data wins unless fetch is waiting and has already lost STARVE_LIMIT times in a row.
    always_comb begin
        grant_d = d_req & ~(i_req & (starve_cnt == LIMIT));
        state_nx = state;
        starve_nx = starve_cnt;
        case (state)
            IDLE: begin
                state_nx = grant_d ? BUSY_D : i_req ? BUSY_I : IDLE;
                starve_nx = (grant_d & i_req) ? ((starve_cnt == LIMIT) ? LIMIT : starve_cnt + ONE) :
                            (grant_d | i_req) ? '0 : starve_cnt;
            end
            BUSY_I: state_nx = m_ack ? DONE_I : BUSY_I;
            BUSY_D: state_nx = m_ack ? DONE_D : BUSY_D;
            default: state_nx = IDLE;
        endcase
    end
    assign start = (state == IDLE) && (state_nx != IDLE);
    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            m_req <= 1'b0;
            m_we <= 1'b0;
            m_addr <= '0;
            m_wdata <= '0;
            gnt_d <= 1'b0;
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            m_req <= (state_nx == BUSY_I) || (state_nx == BUSY_D);
            m_we <= (state_nx == BUSY_D) && (start ? d_we : m_we);
            gnt_d <= (state_nx == BUSY_D) || (state_nx == DONE_D);
            i_ready <= state_nx == DONE_I;
            d_ready <= state_nx == DONE_D;
            if (start) begin
                m_addr <= grant_d ? d_addr : i_addr;
                m_wdata <= grant_d ? d_wdata : '0;
            end
            if (state == BUSY_I && m_ack) i_rdata <= m_rdata;
            if (state == BUSY_D && m_ack && !m_we) d_rdata <= m_rdata;
        end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, latency, starvation guard and async reset
// against a memory responder with programmable ack latency.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic i_req, d_req, d_we, m_ack;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic i_ready, d_ready, m_req, m_we, gnt_d;
    logic [31:0] wr_addr, wr_data;
    logic [9:0] seq;
    int total = 0, bad = 0, lat = 0, cnt = 0, n = 0;
    bit tog;

    mem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .gnt_d(gnt_d)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd(input logic [31:0] a);
        case (a)
            32'h40:  return 32'h8C010004;
            32'h44:  return 32'h12345678;
            32'h200: return 32'hCAFEF00D;
            32'h300: return 32'h0BADF00D;
            default: return ~a;
        endcase
    endfunction

    // Memory responder: acks after `lat` extra cycles of m_req, records writes.
    initial forever begin
        @(negedge clk);
        if (tog) m_ack = (m_ack !== 1'b1);
        else if (rst || !m_req) begin
            m_ack = 1'b0;
            cnt = 0;
        end else if (cnt == lat) begin
            m_ack = 1'b1;
            if (m_we) begin
                wr_addr = m_addr;
                wr_data = m_wdata;
                m_rdata = 32'hA5A5A5A5;
            end else m_rdata = rd(m_addr);
        end else begin
            m_ack = 1'b0;
            cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; tog = 1'b1; lat = 0;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        // Reset with m_ack toggling
        repeat (4) step();
        chk("rst_m_req", {31'b0, m_req}, 0);
        chk("rst_m_we", {31'b0, m_we}, 0);
        chk("rst_gnt_d", {31'b0, gnt_d}, 0);
        chk("rst_readies", {30'b0, i_ready, d_ready}, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        tog = 1'b0; rst = 1'b0;
        repeat (3) begin
            step();
            chk("idle_m_req", {31'b0, m_req}, 0);
            chk("idle_readies", {30'b0, i_ready, d_ready}, 0);
        end
        // Lone fetch, ack in the first m_req cycle
        i_addr = 32'h40; i_req = 1'b1; lat = 0;
        step();
        chk("t2_m_req", {31'b0, m_req}, 1);
        chk("t2_m_we", {31'b0, m_we}, 0);
        chk("t2_m_addr", m_addr, 32'h40);
        chk("t2_early_ready", {31'b0, i_ready}, 0);
        step();
        chk("t2_i_ready", {31'b0, i_ready}, 1);
        chk("t2_d_ready", {31'b0, d_ready}, 0);
        chk("t2_i_rdata", i_rdata, 32'h8C010004);
        chk("t2_m_req_off", {31'b0, m_req}, 0);
        chk("t2_m_we_off", {31'b0, m_we}, 0);
        i_req = 1'b0;
        step();
        chk("t2_ready_pulse", {31'b0, i_ready}, 0);
        // Simultaneous requests: data write first, then fetch
        i_addr = 32'h44; i_req = 1'b1;
        d_addr = 32'h100; d_we = 1'b1; d_wdata = 32'hDEADBEEF; d_req = 1'b1; lat = 3;
        step();
        chk("t3_m_req", {31'b0, m_req}, 1);
        chk("t3_m_we", {31'b0, m_we}, 1);
        chk("t3_m_addr", m_addr, 32'h100);
        chk("t3_m_wdata", m_wdata, 32'hDEADBEEF);
        chk("t3_gnt_d", {31'b0, gnt_d}, 1);
        repeat (3) begin
            step();
            chk("t3_hold_req", {31'b0, m_req}, 1);
            chk("t3_hold_addr", m_addr, 32'h100);
            chk("t3_no_ready", {30'b0, i_ready, d_ready}, 0);
        end
        step();
        chk("t3_d_ready", {31'b0, d_ready}, 1);
        chk("t3_i_ready", {31'b0, i_ready}, 0);
        chk("t3_d_rdata_kept", d_rdata, 0);
        chk("t3_m_req_off", {31'b0, m_req}, 0);
        chk("t3_wr_addr", wr_addr, 32'h100);
        chk("t3_wr_data", wr_data, 32'hDEADBEEF);
        d_req = 1'b0; d_we = 1'b0; lat = 0;
        step();
        chk("t3_idle_m_req", {31'b0, m_req}, 0);
        chk("t3_idle_gnt_d", {31'b0, gnt_d}, 0);
        chk("t3_idle_ready", {31'b0, d_ready}, 0);
        step();
        chk("t3_f_m_req", {31'b0, m_req}, 1);
        chk("t3_f_m_addr", m_addr, 32'h44);
        chk("t3_f_m_we", {31'b0, m_we}, 0);
        chk("t3_f_m_wdata", m_wdata, 0);
        chk("t3_f_gnt_d", {31'b0, gnt_d}, 0);
        step();
        chk("t3_f_i_ready", {31'b0, i_ready}, 1);
        chk("t3_f_i_rdata", i_rdata, 32'h12345678);
        chk("t3_f_d_rdata", d_rdata, 0);
        i_req = 1'b0;
        step();
        // Starvation guard: both held high -> D,D,D,D,I,D,D,D,D,I
        d_addr = 32'h200; d_we = 1'b0; i_addr = 32'h40; d_req = 1'b1; i_req = 1'b1; lat = 0;
        n = 0; seq = '0;
        for (int c = 0; c < 60 && n < 10; c++) begin
            step();
            chk("t4_excl", {31'b0, i_ready & d_ready}, 0);
            if (i_ready || d_ready) begin
                seq[n] = d_ready;
                n++;
            end
        end
        d_req = 1'b0; i_req = 1'b0;
        chk("t4_count", n, 10);
        for (int k = 0; k < 10; k++) chk("t4_grant", {31'b0, seq[k]}, (k % 5 == 4) ? 0 : 1);
        chk("t4_d_rdata", d_rdata, 32'hCAFEF00D);
        chk("t4_i_rdata", i_rdata, 32'h8C010004);
        repeat (2) step();
        // Reset mid data access with ack still pending
        d_addr = 32'h300; d_we = 1'b0; d_req = 1'b1; lat = 5;
        step();
        chk("t5_m_req", {31'b0, m_req}, 1);
        chk("t5_gnt_d", {31'b0, gnt_d}, 1);
        step();
        #2 rst = 1'b1;
        #1;
        chk("t5_async_m_req", {31'b0, m_req}, 0);
        chk("t5_async_gnt_d", {31'b0, gnt_d}, 0);
        step();
        rst = 1'b0; d_req = 1'b0;
        chk("t5_i_rdata_rst", i_rdata, 0);
        chk("t5_d_rdata_rst", d_rdata, 0);
        repeat (8) begin
            step();
            chk("t5_no_ready", {30'b0, i_ready, d_ready}, 0);
            chk("t5_no_req", {31'b0, m_req}, 0);
        end
        i_addr = 32'h40; i_req = 1'b1; lat = 0;
        step();
        chk("t5_f_m_req", {31'b0, m_req}, 1);
        chk("t5_f_m_addr", m_addr, 32'h40);
        step();
        chk("t5_f_i_ready", {31'b0, i_ready}, 1);
        chk("t5_f_d_ready", {31'b0, d_ready}, 0);
        chk("t5_f_i_rdata", i_rdata, 32'h8C010004);
        i_req = 1'b0;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
